// File: rtl/digdug_devbus_arbiter_if.sv
// Signal bundle between the three CPU cores, the device bus arbiter and the I/O device module.
// The arbiter connects through the master modport and its environment through the slave modport.
interface digdug_devbus_arbiter_if;
    logic        PAUSE;
    logic [2:0]  REQ;
    logic [47:0] RQ_AD;
    logic [2:0]  RQ_WR;
    logic [23:0] RQ_DO;
    logic [7:0]  RQ_DI;
    logic [2:0]  ACK;
    logic [2:0]  GNT;
    logic        BUSY;
    logic        TOUT;
    logic [15:0] DEV_AD;
    logic        DEV_RD;
    logic        DEV_WR;
    logic [7:0]  DEV_DI;
    logic        DEV_DV;
    logic [7:0]  DEV_DO;

    modport master (
        input  PAUSE, REQ, RQ_AD, RQ_WR, RQ_DO, DEV_DV, DEV_DO,
        output RQ_DI, ACK, GNT, BUSY, TOUT, DEV_AD, DEV_RD, DEV_WR, DEV_DI
    );

    modport slave (
        output PAUSE, REQ, RQ_AD, RQ_WR, RQ_DO, DEV_DV, DEV_DO,
        input  RQ_DI, ACK, GNT, BUSY, TOUT, DEV_AD, DEV_RD, DEV_WR, DEV_DI
    );
endinterface

// File: rtl/digdug_devbus_arbiter.sv
// Round-robin arbiter serialising main/sub/sound CPU accesses into single-beat device bus
// transactions, with a one-cycle ACK per completion and a DEV_DV timeout for reads.
module digdug_devbus_arbiter #(
    parameter int unsigned TMO = 15
) (
    input  logic MCLK,
    input  logic RESET_N,
    digdug_devbus_arbiter_if.master bus
);
    localparam logic [7:0] TmoCount = 8'(TMO);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wrData_q, wrData_d;
    logic        isWrite_q, isWrite_d;
    logic [7:0]  count_q, count_d;
    logic        tout_q, tout_d;
    logic [7:0]  rdData_q, rdData_d;
    logic [1:0]  pick;

    // Round-robin search starting at the priority pointer; only meaningful when REQ != 0.
    always_comb begin
        pick = 2'd0;
        case (ptr_q)
            2'd0:    pick = bus.REQ[0] ? 2'd0 : (bus.REQ[1] ? 2'd1 : 2'd2);
            2'd1:    pick = bus.REQ[1] ? 2'd1 : (bus.REQ[2] ? 2'd2 : 2'd0);
            default: pick = bus.REQ[2] ? 2'd2 : (bus.REQ[0] ? 2'd0 : 2'd1);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wrData_d  = wrData_q;
        isWrite_d = isWrite_q;
        count_d   = count_q;
        tout_d    = tout_q;
        rdData_d  = rdData_q;
        case (state_q)
            IDLE: begin
                if (!bus.PAUSE && bus.REQ != 3'b000) begin
                    owner_d   = pick;
                    addr_d    = bus.RQ_AD[{pick, 4'b0000} +: 16];
                    wrData_d  = bus.RQ_DO[{pick, 3'b000} +: 8];
                    isWrite_d = bus.RQ_WR[pick];
                    ptr_d     = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                    count_d   = 8'd0;
                    tout_d    = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (isWrite_q) begin
                    state_d = DONE;
                end else if (bus.DEV_DV) begin
                    rdData_d = bus.DEV_DO;
                    state_d  = DONE;
                end else if (count_q + 8'd1 == TmoCount) begin
                    // The device never answered: complete with all-ones data and flag it.
                    count_d  = count_q + 8'd1;
                    rdData_d = 8'hFF;
                    tout_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    count_d = count_q + 8'd1;
                    state_d = WAIT;
                end
            end
            default: begin
                count_d = 8'd0;
                tout_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            addr_q    <= 16'h0000;
            wrData_q  <= 8'h00;
            isWrite_q <= 1'b0;
            count_q   <= 8'd0;
            tout_q    <= 1'b0;
            rdData_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wrData_q  <= wrData_d;
            isWrite_q <= isWrite_d;
            count_q   <= count_d;
            tout_q    <= tout_d;
            rdData_q  <= rdData_d;
        end
    end

    // Outputs decode registered state only, so a reset clears the strobes immediately.
    assign bus.BUSY   = (state_q != IDLE);
    assign bus.GNT    = (state_q != IDLE) ? (3'b001 << owner_q) : 3'b000;
    assign bus.ACK    = (state_q == DONE) ? (3'b001 << owner_q) : 3'b000;
    assign bus.TOUT   = (state_q == DONE) && tout_q;
    assign bus.DEV_WR = (state_q == ISSUE) && isWrite_q;
    assign bus.DEV_RD = ((state_q == ISSUE) || (state_q == WAIT)) && !isWrite_q;
    assign bus.DEV_AD = addr_q;
    assign bus.DEV_DI = wrData_q;
    assign bus.RQ_DI  = rdData_q;
endmodule

// File: tb/tb_digdug_devbus_arbiter.sv
// Self-checking bench for the DigDug device bus arbiter: a vector table of transactions plus
// hand-written PAUSE and mid-transaction reset sequences, with ACKs checked against a scoreboard.
module tb_digdug_devbus_arbiter;
    localparam int Tmo = 15;

    logic MCLK = 1'b0;
    logic RESET_N = 1'b0;
    int   checks = 0;
    int   errors = 0;

    digdug_devbus_arbiter_if bus();

    digdug_devbus_arbiter #(.TMO(Tmo)) dut (
        .MCLK(MCLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic [2:0] ack;
        logic [7:0] di;
        logic       tout;
    } exp_t;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  wr;
        logic [15:0] baseAd;
        logic [7:0]  baseDo;
        int          dvWait;
        logic [7:0]  devDo;
        logic [2:0]  expGnt;
        logic [7:0]  expDi;
        logic        expTout;
        int          expRd;
        int          expWr;
        int          expAck;
    } vec_t;

    exp_t sbQ[$];
    exp_t monExp;
    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Every ACK pulse is matched against the oldest outstanding expectation.
    always @(negedge MCLK) begin
        if (bus.ACK != 3'b000) begin
            if (sbQ.size() == 0) begin
                checkOutput("ackUnexpected", 32'(bus.ACK), 32'd0);
            end else begin
                monExp = sbQ.pop_front();
                checkOutput("ackMask", 32'(bus.ACK), 32'(monExp.ack));
                checkOutput("rqDi", 32'(bus.RQ_DI), 32'(monExp.di));
                checkOutput("tout", 32'(bus.TOUT), 32'(monExp.tout));
            end
        end
        if (bus.TOUT) checkOutput("toutWithAck", 32'(bus.ACK != 3'b000), 32'd1);
        checkOutput("gntOneHot", 32'($onehot0(bus.GNT)), 32'd1);
    end

    task automatic setFields(input logic [15:0] baseAd, input logic [7:0] baseDo);
        for (int i = 0; i < 3; i++) begin
            bus.RQ_AD[i*16 +: 16] = baseAd + 16'(i * 256);
            bus.RQ_DO[i*8 +: 8]   = baseDo + 8'(i);
        end
    endtask

    task automatic pushExp(input logic [2:0] ack, input logic [7:0] di, input logic tout);
        exp_t e;
        e.ack  = ack;
        e.di   = di;
        e.tout = tout;
        sbQ.push_back(e);
    endtask

    // Called at the negedge of the first ISSUE cycle; returns at the negedge of the ACK cycle.
    task automatic waitAck(input int dvWait, input logic [7:0] devDo, input logic [15:0] expAd,
                           input logic [7:0] expDi, input logic isWr,
                           output int cyc, output int rdCnt, output int wrCnt);
        bit gotAck;
        cyc = 0; rdCnt = 0; wrCnt = 0; gotAck = 0;
        while (!gotAck && cyc < 300) begin
            if (bus.ACK != 3'b000) begin
                gotAck  = 1;
                bus.REQ = bus.REQ & ~bus.ACK;
            end else begin
                if (bus.DEV_RD) rdCnt++;
                if (bus.DEV_WR) wrCnt++;
                if (cyc == 0) begin
                    checkOutput("devAd", 32'(bus.DEV_AD), 32'(expAd));
                    if (isWr) checkOutput("devDi", 32'(bus.DEV_DI), 32'(expDi));
                end
                bus.DEV_DV = (dvWait >= 0) && bus.DEV_RD && (rdCnt == dvWait + 1);
                bus.DEV_DO = bus.DEV_DV ? devDo : ~devDo;
                @(negedge MCLK);
                cyc++;
            end
        end
        bus.DEV_DV = 1'b0;
        checkOutput("ackSeen", 32'(gotAck), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int cyc, rdCnt, wrCnt, g;
        @(negedge MCLK);
        bus.REQ   = v.req;
        bus.RQ_WR = v.wr;
        setFields(v.baseAd, v.baseDo);
        pushExp(v.expGnt, v.expDi, v.expTout);
        @(negedge MCLK);
        checkOutput("gnt", 32'(bus.GNT), 32'(v.expGnt));
        g = v.expGnt[1] ? 1 : (v.expGnt[2] ? 2 : 0);
        waitAck(v.dvWait, v.devDo, v.baseAd + 16'(g * 256), v.baseDo + 8'(g), v.wr[g], cyc, rdCnt, wrCnt);
        checkOutput("rdCycles", 32'(rdCnt), 32'(v.expRd));
        checkOutput("wrCycles", 32'(wrCnt), 32'(v.expWr));
        checkOutput("ackCycle", 32'(cyc + 1), 32'(v.expAck));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, rdCnt, wrCnt, busyCycles;

        // req, wr, baseAd, baseDo, dvWait, devDo, expGnt, expDi, expTout, expRd, expWr, expAck
        vecs[0]  = '{3'b001, 3'b001, 16'h6800, 8'h5A, -1, 8'h00, 3'b001, 8'h00, 1'b0, 0,   1, 2};
        vecs[1]  = '{3'b010, 3'b010, 16'h7000, 8'h10, -1, 8'h00, 3'b010, 8'h00, 1'b0, 0,   1, 2};
        vecs[2]  = '{3'b100, 3'b100, 16'h7100, 8'h20, -1, 8'h00, 3'b100, 8'h00, 1'b0, 0,   1, 2};
        vecs[3]  = '{3'b111, 3'b111, 16'h7200, 8'h30, -1, 8'h00, 3'b001, 8'h00, 1'b0, 0,   1, 2};
        vecs[4]  = '{3'b111, 3'b000, 16'h7300, 8'h40,  0, 8'h3C, 3'b010, 8'h3C, 1'b0, 1,   0, 2};
        vecs[5]  = '{3'b111, 3'b011, 16'h7400, 8'h50,  1, 8'hA5, 3'b100, 8'hA5, 1'b0, 2,   0, 3};
        vecs[6]  = '{3'b111, 3'b111, 16'h7500, 8'h60, -1, 8'h00, 3'b001, 8'hA5, 1'b0, 0,   1, 2};
        vecs[7]  = '{3'b100, 3'b000, 16'h9000, 8'h70,  3, 8'hC3, 3'b100, 8'hC3, 1'b0, 4,   0, 5};
        vecs[8]  = '{3'b001, 3'b000, 16'h9100, 8'h80, -1, 8'h00, 3'b001, 8'hFF, 1'b1, Tmo, 0, Tmo + 1};
        vecs[9]  = '{3'b011, 3'b011, 16'h9200, 8'h90, -1, 8'h00, 3'b010, 8'hFF, 1'b0, 0,   1, 2};
        vecs[10] = '{3'b011, 3'b000, 16'h9300, 8'hA0,  0, 8'h77, 3'b001, 8'h77, 1'b0, 1,   0, 2};

        bus.PAUSE = 1'b0; bus.REQ = 3'b000; bus.RQ_WR = 3'b000;
        bus.RQ_AD = 48'h0; bus.RQ_DO = 24'h0; bus.DEV_DV = 1'b0; bus.DEV_DO = 8'h00;
        #3;
        checkOutput("rstGnt", 32'(bus.GNT), 32'd0);
        checkOutput("rstAck", 32'(bus.ACK), 32'd0);
        checkOutput("rstBusy", 32'(bus.BUSY), 32'd0);
        checkOutput("rstStrobes", 32'({bus.DEV_RD, bus.DEV_WR, bus.TOUT}), 32'd0);
        checkOutput("rstDevAd", 32'(bus.DEV_AD), 32'd0);
        checkOutput("rstRqDi", 32'(bus.RQ_DI), 32'd0);
        repeat (2) @(negedge MCLK);
        RESET_N = 1'b1;

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // PAUSE holds off a pending request, then a read granted on release survives PAUSE rising again.
        @(negedge MCLK);
        bus.PAUSE = 1'b1; bus.REQ = 3'b010; bus.RQ_WR = 3'b000;
        setFields(16'hB000, 8'hB0);
        busyCycles = 0;
        repeat (20) begin
            @(negedge MCLK);
            if (bus.GNT != 3'b000 || bus.BUSY) busyCycles++;
        end
        checkOutput("pauseNoGnt", 32'(busyCycles), 32'd0);
        bus.PAUSE = 1'b0;
        pushExp(3'b010, 8'h96, 1'b0);
        @(negedge MCLK);
        checkOutput("pauseReleaseGnt", 32'(bus.GNT), 32'(3'b010));
        bus.PAUSE = 1'b1;
        waitAck(2, 8'h96, 16'hB100, 8'hB1, 1'b0, cyc, rdCnt, wrCnt);
        checkOutput("pauseRdCycles", 32'(rdCnt), 32'd3);
        checkOutput("pauseAckCycle", 32'(cyc + 1), 32'd4);
        bus.PAUSE = 1'b0;

        // Asynchronous reset during WAIT aborts the read; pointer restarts at requester 0.
        @(negedge MCLK);
        bus.REQ = 3'b001; bus.RQ_WR = 3'b000;
        setFields(16'hC000, 8'hC0);
        @(negedge MCLK);
        checkOutput("abortGnt", 32'(bus.GNT), 32'(3'b001));
        @(negedge MCLK);
        checkOutput("abortWaitRd", 32'(bus.DEV_RD), 32'd1);
        #2;
        RESET_N = 1'b0;
        bus.REQ = 3'b011; bus.RQ_WR = 3'b011;
        #1;
        checkOutput("abortRd", 32'(bus.DEV_RD), 32'd0);
        checkOutput("abortGntDrop", 32'(bus.GNT), 32'd0);
        checkOutput("abortBusy", 32'(bus.BUSY), 32'd0);
        checkOutput("abortAck", 32'(bus.ACK), 32'd0);
        repeat (2) @(negedge MCLK);
        RESET_N = 1'b1;
        pushExp(3'b001, 8'h00, 1'b0);
        @(negedge MCLK);
        checkOutput("postRstGnt", 32'(bus.GNT), 32'(3'b001));
        waitAck(-1, 8'h00, 16'hC000, 8'hC0, 1'b1, cyc, rdCnt, wrCnt);
        bus.REQ = 3'b000;
        checkOutput("postRstWrCycles", 32'(wrCnt), 32'd1);

        repeat (3) @(negedge MCLK);
        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
